// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM states and the legal response-latency window.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store request/response bundle; the core is the master,
// the data memory responder is the slave.
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering for RISC-V sub-word accesses: store byte enables and
// lane replication, load lane extraction with sign/zero extension.
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        bad
);

   logic signed [7:0]  rbyte_s;
   logic signed [15:0] rhalf_s;

   assign rbyte_s = rword[{addr_lo, 3'b000} +: 8];
   assign rhalf_s = addr_lo[1] ? rword[31:16] : rword[15:0];

   // Store data is replicated into every lane; the byte enables pick the live one.
   always_comb begin
      be        = 4'b0000;
      wdata_sh  = '0;
      rdata_ext = '0;
      bad       = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << addr_lo;
            wdata_sh  = {4{wdata[7:0]}};
            rdata_ext = (funct3 == F3_B) ? {{24{rbyte_s[7]}}, rbyte_s}
                                         : {24'h0, rbyte_s};
         end
         F3_H, F3_HU: begin
            bad       = addr_lo[0];
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh  = {2{wdata[15:0]}};
            rdata_ext = (funct3 == F3_H) ? {{16{rhalf_s[15]}}, rhalf_s}
                                         : {16'h0, rhalf_s};
         end
         F3_W: begin
            bad       = (addr_lo != 2'b00);
            be        = 4'b1111;
            wdata_sh  = wdata;
            rdata_ext = rword;
         end
         default: bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word array, accept/wait/respond
// FSM, latency counter and registered response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("dmem_responder: LATENCY out of range");
   end

   localparam int         DEPTH        = 2 ** ADDR_W;
   localparam state_t     ACCEPT_STATE = (LATENCY > 1) ? WAIT : RESP;
   localparam logic [1:0] WAIT_INIT    = 2'(LATENCY - 2);

   logic [31:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        valid_q, valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [ADDR_W-1:0] widx;
   logic              out_of_range;
   logic              unsigned_store;
   logic              accept;
   logic              req_err;
   logic              wr_en;
   logic [3:0]        be;
   logic [31:0]       wdata_sh;
   logic [31:0]       rdata_ext;
   logic              align_bad;

   assign widx           = bus.req_addr[ADDR_W+1:2];
   assign out_of_range   = |bus.req_addr[31:ADDR_W+2];
   assign unsigned_store = bus.req_we &&
                           (bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU);
   assign accept         = ready_q && bus.req_valid;
   assign req_err        = align_bad || out_of_range || unsigned_store;
   assign wr_en          = accept && bus.req_we && !req_err && !rst;

   dmem_align u_align (
      .addr_lo   (bus.req_addr[1:0]),
      .funct3    (bus.req_funct3),
      .wdata     (bus.req_wdata),
      .rword     (mem[widx]),
      .be        (be),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext),
      .bad       (align_bad)
   );

   // Stores land at the acceptance edge, so any later load sees them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACCEPT_STATE;
               cnt_d   = (LATENCY > 1) ? WAIT_INIT : 2'd0;
               err_d   = req_err;
               rdata_d = (req_err || bus.req_we) ? 32'h0 : rdata_ext;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs are registered copies of the next state.
      ready_d = (state_d == IDLE);
      valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1 for the
// load/store function, one at LATENCY=3 for backpressure and reset.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic rst3;

   always #5 clk = ~clk;

   dmem_responder_if if1 ();
   dmem_responder_if if3 ();

   dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
      .clk (clk),
      .rst (rst3),
      .bus (if3.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus(virtual dmem_responder_if vif);
      vif.req_valid  = 1'b0;
      vif.req_we     = 1'b0;
      vif.req_addr   = 32'h0;
      vif.req_wdata  = 32'h0;
      vif.req_funct3 = 3'b000;
      vif.rsp_ready  = 1'b1;
   endtask

   // One complete transaction with rsp_ready high; exp_wait is the number of
   // edges between acceptance and the edge that raises rsp_valid.
   task automatic txn(virtual dmem_responder_if vif, input string tag,
                      input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_wait);
      int n;
      vif.req_valid  = 1'b1;
      vif.req_we     = we;
      vif.req_addr   = addr;
      vif.req_wdata  = wdata;
      vif.req_funct3 = f3;
      vif.rsp_ready  = 1'b1;
      n = 0;
      while (!vif.req_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check({tag, ".ready_timeout"}, 32'd0, 32'd1);
      tick();
      vif.req_valid = 1'b0;
      n = 0;
      while (!vif.rsp_valid && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         check({tag, ".rsp_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, ".latency"}, n, exp_wait);
         check({tag, ".rdata"}, vif.rsp_rdata, exp_rd);
         check({tag, ".err"}, {31'b0, vif.rsp_err}, {31'b0, exp_err});
      end
      tick();
      idle_bus(vif);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst  = 1'b1;
      rst3 = 1'b1;
      idle_bus(if1);
      idle_bus(if3);
      repeat (3) tick();
      check("rst.ready1", {31'b0, if1.req_ready}, 32'd0);
      check("rst.valid1", {31'b0, if1.rsp_valid}, 32'd0);
      check("rst.rdata1", if1.rsp_rdata, 32'h0);
      check("rst.err1",   {31'b0, if1.rsp_err}, 32'd0);
      check("rst.ready3", {31'b0, if3.req_ready}, 32'd0);
      check("rst.valid3", {31'b0, if3.rsp_valid}, 32'd0);
      rst  = 1'b0;
      rst3 = 1'b0;
      tick();
      check("rel.ready1", {31'b0, if1.req_ready}, 32'd1);
      check("rel.ready3", {31'b0, if3.req_ready}, 32'd1);

      // Word round trip and sub-word reads of the same word
      txn(if1, "sw10",   1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
      txn(if1, "lw10",   1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
      txn(if1, "lh12",   1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 0);
      txn(if1, "lhu10",  1'b0, F3_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 0);
      txn(if1, "lbu13",  1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, 0);
      txn(if1, "lb10",   1'b0, F3_B,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 0);

      // Byte store into lane 1; upper wdata bits must be ignored
      txn(if1, "sw20",   1'b1, F3_W,  32'h20, 32'h11223344, 32'h0,        1'b0, 0);
      txn(if1, "sb21",   1'b1, F3_B,  32'h21, 32'h12345680, 32'h0,        1'b0, 0);
      txn(if1, "lb21",   1'b0, F3_B,  32'h21, 32'h0,        32'hFFFFFF80, 1'b0, 0);
      txn(if1, "lbu21",  1'b0, F3_BU, 32'h21, 32'h0,        32'h00000080, 1'b0, 0);
      txn(if1, "lw20",   1'b0, F3_W,  32'h20, 32'h0,        32'h11228044, 1'b0, 0);
      txn(if1, "lbu23",  1'b0, F3_BU, 32'h23, 32'h0,        32'h00000011, 1'b0, 0);

      // Halfword store into the upper lanes
      txn(if1, "sw30",   1'b1, F3_W,  32'h30, 32'h0,        32'h0,        1'b0, 0);
      txn(if1, "sh32",   1'b1, F3_H,  32'h32, 32'hABCD8001, 32'h0,        1'b0, 0);
      txn(if1, "lh32",   1'b0, F3_H,  32'h32, 32'h0,        32'hFFFF8001, 1'b0, 0);
      txn(if1, "lw30",   1'b0, F3_W,  32'h30, 32'h0,        32'h80010000, 1'b0, 0);
      txn(if1, "lhu30",  1'b0, F3_HU, 32'h30, 32'h0,        32'h00000000, 1'b0, 0);
      txn(if1, "lb33",   1'b0, F3_B,  32'h33, 32'h0,        32'hFFFFFF80, 1'b0, 0);

      // Error cases: none of the failing stores may touch the array
      txn(if1, "lw13",   1'b0, F3_W,  32'h13, 32'h0,        32'h0,        1'b1, 0);
      txn(if1, "sh31",   1'b1, F3_H,  32'h31, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
      txn(if1, "sbu30",  1'b1, F3_BU, 32'h30, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
      txn(if1, "lw30b",  1'b0, F3_W,  32'h30, 32'h0,        32'h80010000, 1'b0, 0);
      txn(if1, "f3_011", 1'b0, 3'b011, 32'h10, 32'h0,       32'h0,        1'b1, 0);
      txn(if1, "f3_110", 1'b0, 3'b110, 32'h10, 32'h0,       32'h0,        1'b1, 0);
      txn(if1, "sw0",    1'b1, F3_W,  32'h0,    32'h55AA55AA, 32'h0,      1'b0, 0);
      txn(if1, "sw1000", 1'b1, F3_W,  32'h1000, 32'hFFFFFFFF, 32'h0,      1'b1, 0);
      txn(if1, "lw1000", 1'b0, F3_W,  32'h1000, 32'h0,        32'h0,      1'b1, 0);
      txn(if1, "lw0",    1'b0, F3_W,  32'h0,    32'h0,        32'h55AA55AA, 1'b0, 0);

      // LATENCY=3 with held-off response and a competing request
      txn(if3, "l3_sw40", 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2);
      if3.rsp_ready  = 1'b0;
      if3.req_valid  = 1'b1;
      if3.req_we     = 1'b0;
      if3.req_addr   = 32'h40;
      if3.req_funct3 = F3_W;
      tick();
      check("bp.ready_t0", {31'b0, if3.req_ready}, 32'd0);
      check("bp.valid_t0", {31'b0, if3.rsp_valid}, 32'd0);
      if3.req_we    = 1'b1;
      if3.req_wdata = 32'h0BADBEEF;
      tick();
      check("bp.valid_t1", {31'b0, if3.rsp_valid}, 32'd0);
      tick();
      check("bp.valid_t2", {31'b0, if3.rsp_valid}, 32'd1);
      check("bp.rdata_t2", if3.rsp_rdata, 32'hCAFEF00D);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp.hold_valid", {31'b0, if3.rsp_valid}, 32'd1);
         check("bp.hold_rdata", if3.rsp_rdata, 32'hCAFEF00D);
         check("bp.hold_ready", {31'b0, if3.req_ready}, 32'd0);
      end
      if3.rsp_ready = 1'b1;
      tick();
      check("bp.valid_hs", {31'b0, if3.rsp_valid}, 32'd0);
      check("bp.ready_hs", {31'b0, if3.req_ready}, 32'd1);
      idle_bus(if3);
      txn(if3, "l3_lw40", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2);

      // Reset while a store sits in WAIT: no response, store still committed
      if3.req_valid  = 1'b1;
      if3.req_we     = 1'b1;
      if3.req_addr   = 32'h44;
      if3.req_wdata  = 32'h600DF00D;
      if3.req_funct3 = F3_W;
      tick();
      idle_bus(if3);
      rst3 = 1'b1;
      tick();
      check("mid.valid", {31'b0, if3.rsp_valid}, 32'd0);
      check("mid.ready", {31'b0, if3.req_ready}, 32'd0);
      rst3 = 1'b0;
      tick();
      check("mid.ready_rel", {31'b0, if3.req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("mid.no_rsp", {31'b0, if3.rsp_valid}, 32'd0);
         tick();
      end
      txn(if3, "l3_lw44", 1'b0, F3_W, 32'h44, 32'h0, 32'h600DF00D, 1'b0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core: the slave end of the MEM-stage load/store request interface. It accepts one request at a time over a valid/ready handshake and performs RISC-V byte, halfword and word loads and stores against an internal word-organised array. It returns read data, sign- or zero-extended, with an error flag after a configurable latency. The core's MEM stage stalls on this handshake through hazard_detection.

## Interface
Parameters:
- ADDR_W, 10: word-address bits; array depth is 2**ADDR_W words of 32 bits.
- LATENCY, 1: cycles from request acceptance to rsp_valid; legal range 1..4.

Ports:
- clk, input, 1: the single clock; all logic on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request.
- req_we, input, 1: 1 = store, 0 = load.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- req_funct3, input, 3: RISC-V funct3. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU (BU/HU are loads only).
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: core accepts the response.
- rsp_rdata, output, 32: load result; 0 for stores and errors.
- rsp_err, output, 1: misaligned, out-of-range or illegal funct3.

## Operation
- FSM states:
  - IDLE: req_ready = 1. On req_valid, accept the request. Go to WAIT if LATENCY > 1, else go to RESP.
  - WAIT: count LATENCY-1 cycles, then go to RESP.
  - RESP: hold rsp_valid = 1 and keep rsp_rdata and rsp_err stable. On rsp_ready, go to IDLE.
- Only one transaction is outstanding. req_ready is 0 in WAIT and RESP.
- All request fields are sampled only at the acceptance edge. Later changes to the inputs have no effect.
- Error conditions, checked at acceptance:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - funct3 in {011, 110, 111}.
  - Store with funct3 = 100 or 101.
  - addr[31:ADDR_W+2] != 0.
  - On error, the array is not written, rsp_err = 1 and rsp_rdata = 0.
- Stores:
  - The write is committed at the acceptance edge.
  - Byte enables come from addr[1:0] and size. SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all lanes.
  - rsp_rdata = 0.
- Loads:
  - The word is read at acceptance and registered.
  - Lane select is by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
  - The result is held until the response handshake.
- A load that directly follows a store to the same word returns the stored data. No stale read is allowed.
- Array contents are not reset and are undefined at power-up.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 while rst is high, and 1 from the first cycle after rst drops.
- Latency:
  - Request accepted at edge T: rsp_valid = 1 from the cycle after edge T+LATENCY-1. For LATENCY = 1, this is the cycle after acceptance.
- Throughput: back-to-back requests issue at most one per LATENCY+1 cycles, with rsp_ready tied high.
- Backpressure: with rsp_ready = 0, the response holds indefinitely and req_ready stays 0.
- Same-cycle events: req_valid has no effect outside IDLE, including during the cycle in which the RESP handshake completes. The next accept is earliest the cycle after the handshake.
- Reset mid-transaction:
  - An in-flight load is abandoned and no response is given.
  - A store already accepted stays committed.
- req_ready and rsp_valid are decoded from registered state only. There is no combinational path from req_valid or rsp_ready to any output.

## Structure
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum IDLE/WAIT/RESP.
  - LATENCY bounds.
- Sub-module dmem_align (combinational):
  - Inputs: addr[1:0], funct3, wdata, read word.
  - Outputs: 4-bit byte-enable, lane-shifted write data, extended load data, misalign/illegal flag.
- The top level holds the array, FSM, latency counter and response registers.

## Test plan
- Word round trip: SW 0xDEADBEEF @0x10, then LW @0x10. Load response is 0xDEADBEEF with rsp_err = 0. Store response has rdata = 0.
- Byte extension: SB 0x80 @0x21, then LB @0x21 returns 0xFFFFFF80 and LBU @0x21 returns 0x00000080. Other bytes of word 0x20 are unchanged.
- Halfword lane: SH 0x8001 @0x32, then LH @0x32 returns 0xFFFF8001 and LW @0x30 has [31:16] = 0x8001.
- Errors:
  - LW @0x13 gives rsp_err = 1, rdata = 0.
  - SW @0x1000 (ADDR_W = 10) gives err with no write, checked by a later LW @0x0 being unchanged.
  - funct3 = 011 gives err.
- Backpressure and latency: LATENCY = 3 with rsp_ready low for 5 cycles. rsp_valid rises exactly 3 cycles after accept, rsp_rdata holds stable, req_ready stays 0, and a new req_valid is ignored until one cycle after the handshake.
- Reset mid-operation: assert rst while in WAIT. The next cycle has rsp_valid = 0, and req_ready = 1 after rst is released.
